// File: rtl/hwpe_stream_job_ctrl.sv
// Job controller driving one HWPE stream source/sink pair through n_iter start/done handshakes.
// Field layout: base_addr is the top ADDR_W bits of the addressgen word, and ready_start/done are flag bits 28/27.
module hwpe_stream_job_ctrl #(
    parameter int unsigned NB_ITER_W = 16,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [153:0]         src_addrgen_i,
    input  logic [153:0]         snk_addrgen_i,
    input  logic [NB_ITER_W-1:0] n_iter_i,
    input  logic [ADDR_W-1:0]    src_stride_i,
    input  logic [ADDR_W-1:0]    snk_stride_i,
    output logic [154:0]         src_ctrl_o,
    input  logic [28:0]          src_flags_i,
    output logic [154:0]         snk_ctrl_o,
    input  logic [28:0]          snk_flags_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [NB_ITER_W-1:0] iter_o
);

    localparam int unsigned AG_W     = 154;
    localparam int unsigned FL_READY = 28;
    localparam int unsigned FL_DONE  = 27;

    typedef enum logic [1:0] {IDLE, WAIT_READY, REQ, RUN} state_e;

    state_e                 state_q, state_d;
    logic [AG_W-1:0]        src_ag_q, src_ag_d;
    logic [AG_W-1:0]        snk_ag_q, snk_ag_d;
    logic [NB_ITER_W-1:0]   n_iter_q, n_iter_d;
    logic [NB_ITER_W-1:0]   iter_q, iter_d;
    logic [ADDR_W-1:0]      src_stride_q, src_stride_d;
    logic [ADDR_W-1:0]      snk_stride_q, snk_stride_d;
    logic                   src_done_q, src_done_d;
    logic                   snk_done_q, snk_done_d;
    logic                   req_q, req_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    logic                   both_ready;
    logic                   iter_end;
    logic [NB_ITER_W:0]     iter_nxt;
    logic                   unused_flags;

    assign unused_flags = ^{src_flags_i[FL_DONE-1:0], snk_flags_i[FL_DONE-1:0]};

    assign both_ready = src_flags_i[FL_READY] & snk_flags_i[FL_READY];
    // A done arriving in the current cycle counts together with the sticky flags.
    assign iter_end   = (src_done_q | src_flags_i[FL_DONE]) & (snk_done_q | snk_flags_i[FL_DONE]);
    assign iter_nxt   = {1'b0, iter_q} + (NB_ITER_W+1)'(1);

    always_comb begin
        state_d      = state_q;
        src_ag_d     = src_ag_q;
        snk_ag_d     = snk_ag_q;
        n_iter_d     = n_iter_q;
        iter_d       = iter_q;
        src_stride_d = src_stride_q;
        snk_stride_d = snk_stride_q;
        src_done_d   = src_done_q;
        snk_done_d   = snk_done_q;
        req_d        = 1'b0;
        done_d       = 1'b0;
        busy_d       = busy_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    src_ag_d     = src_addrgen_i;
                    snk_ag_d     = snk_addrgen_i;
                    n_iter_d     = (n_iter_i == '0) ? NB_ITER_W'(1) : n_iter_i;
                    src_stride_d = src_stride_i;
                    snk_stride_d = snk_stride_i;
                    iter_d       = '0;
                    busy_d       = 1'b1;
                    state_d      = WAIT_READY;
                end
            end
            WAIT_READY: begin
                if (both_ready) begin
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                src_done_d = 1'b0;
                snk_done_d = 1'b0;
                state_d    = RUN;
            end
            RUN: begin
                src_done_d = src_done_q | src_flags_i[FL_DONE];
                snk_done_d = snk_done_q | snk_flags_i[FL_DONE];
                if (iter_end) begin
                    if (iter_nxt < {1'b0, n_iter_q}) begin
                        iter_d                        = iter_nxt[NB_ITER_W-1:0];
                        src_ag_d[AG_W-1 -: ADDR_W]    = src_ag_q[AG_W-1 -: ADDR_W] + src_stride_q;
                        snk_ag_d[AG_W-1 -: ADDR_W]    = snk_ag_q[AG_W-1 -: ADDR_W] + snk_stride_q;
                        state_d                       = WAIT_READY;
                    end else begin
                        iter_d  = '0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear wins over everything, including a start in the same cycle.
        if (clear_i) begin
            state_d      = IDLE;
            src_ag_d     = '0;
            snk_ag_d     = '0;
            n_iter_d     = '0;
            iter_d       = '0;
            src_stride_d = '0;
            snk_stride_d = '0;
            src_done_d   = 1'b0;
            snk_done_d   = 1'b0;
            req_d        = 1'b0;
            done_d       = 1'b0;
            busy_d       = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            src_ag_q     <= '0;
            snk_ag_q     <= '0;
            n_iter_q     <= '0;
            iter_q       <= '0;
            src_stride_q <= '0;
            snk_stride_q <= '0;
            src_done_q   <= 1'b0;
            snk_done_q   <= 1'b0;
            req_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_ag_q     <= src_ag_d;
            snk_ag_q     <= snk_ag_d;
            n_iter_q     <= n_iter_d;
            iter_q       <= iter_d;
            src_stride_q <= src_stride_d;
            snk_stride_q <= snk_stride_d;
            src_done_q   <= src_done_d;
            snk_done_q   <= snk_done_d;
            req_q        <= req_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign src_ctrl_o = {req_q, src_ag_q};
    assign snk_ctrl_o = {req_q, snk_ag_q};
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign iter_o     = iter_q;

endmodule

// File: doc/hwpe_stream_job_ctrl.md
Name: hwpe_stream_job_ctrl

Overview:
- Initiator-side controller for one HWPE stream source and one stream sink; the controller is the counterpart of their start/done protocol.
- Latches a job configuration and drives ctrl_sourcesink_t to both units.
- Issues a synchronized req_start, collects both done flags, and repeats the transfer n_iter times with per-iteration base-address strides.
- Sits between the engine's register-file/FSM and the source/sink pair.

Parameters:
- NB_ITER_W, 16, width of iteration counter and n_iter_i.
- ADDR_W, 32, base-address width; must equal ctrl_addressgen_t.base_addr width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
- clear_i  in  1  synchronous clear, same effect as reset.
- start_i  in  1  job start pulse; accepted only in IDLE.
- src_addrgen_i  in  154  ctrl_addressgen_t for source, sampled on accepted start.
- snk_addrgen_i  in  154  ctrl_addressgen_t for sink, sampled on accepted start.
- n_iter_i  in  NB_ITER_W  iteration count; 0 treated as 1.
- src_stride_i  in  ADDR_W  source base_addr increment per iteration.
- snk_stride_i  in  ADDR_W  sink base_addr increment per iteration.
- src_ctrl_o  out  155  ctrl_sourcesink_t to source.
- src_flags_i  in  29  flags_sourcesink_t from source (ready_start, done used).
- snk_ctrl_o  out  155  ctrl_sourcesink_t to sink.
- snk_flags_i  in  29  flags_sourcesink_t from sink.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle pulse at job end.
- iter_o  out  NB_ITER_W  current iteration index (0-based).

Behaviour:
- States: IDLE, WAIT_READY, REQ, RUN. Reset/clear → IDLE.
- Reset values: all outputs 0; addressgen registers 0; sticky done flags 0; iter 0.
- Config latch:
  - On start_i in IDLE, latch both addressgen structs, n_iter (0→1) and strides.
  - Go to WAIT_READY.
  - start_i outside IDLE is ignored; no queueing.
- addressgen_ctrl fields of src_ctrl_o/snk_ctrl_o are driven from the latched registers only.
  - They are stable from WAIT_READY through RUN.
  - They hold their last value in IDLE.
- WAIT_READY: stay until src ready_start and snk ready_start are both 1 in the same cycle, then go to REQ next cycle.
- REQ:
  - req_start=1 on both src_ctrl_o and snk_ctrl_o for exactly one cycle.
  - Clear both sticky done flags, then go to RUN.
  - req_start is 0 in every other state.
- RUN:
  - src_done_q is set on src_flags_i.done; snk_done_q is set on snk_flags_i.done.
  - A done arriving in the same cycle counts immediately, i.e. iteration_end = (src_done_q|src done) & (snk_done_q|snk done).
  - Dones may arrive in any order or simultaneously.
  - Done flags seen outside RUN are ignored.
- Iteration end with iter+1 < n_iter:
  - iter increments.
  - src base_addr += src_stride and snk base_addr += snk_stride, modulo 2^ADDR_W; other fields are unchanged.
  - Go to WAIT_READY.
- Iteration end with iter+1 == n_iter:
  - done_o=1 for one cycle, in the cycle after iteration end.
  - Go to IDLE; iter is reset to 0 on the IDLE entry.
- busy_o: deasserted in the same cycle done_o pulses. A start_i in the done_o cycle is accepted.
- clear_i:
  - Has priority over all events, including start_i in the same cycle.
  - Aborts mid-job without a done_o pulse.
  - req_start=0 the following cycle.
- Latency:
  - start_i to first req_start is ≥2 cycles (WAIT_READY, then REQ); exactly 2 if both units are ready.
  - Last done to done_o is 1 cycle.
  - Iteration end to next req_start is ≥2 cycles.

Test Plan:
- Single job, n_iter=1, both ready, src done at cycle 10 and snk done at cycle 14 after req_start → done_o pulses exactly once at cycle 15, busy_o low from cycle 15.
- n_iter=3, src base 0x1000 stride 0x100, snk base 0x8000 stride 0x40 → three req_start pulses; src base_addr 0x1000/0x1100/0x1200 and snk 0x8000/0x8040/0x8080; iter_o 0,1,2.
- Sink ready_start held low for 20 cycles after start → no req_start until both ready; req_start pulse width is 1 cycle on both outputs simultaneously.
- Both dones in same cycle; also a spurious done while in IDLE/WAIT_READY → iteration completes on the simultaneous dones; spurious done produces no state change.
- Wrap and zero: src base 0xFFFFFF00, stride 0x100, n_iter=2 → second base 0x00000000; n_iter=0 → behaves as 1 iteration.
- clear_i during RUN of iteration 1, and start_i during busy → IDLE next cycle, no done_o, iter_o=0; start during busy is ignored with no effect on latched config.
